lemming_bump_cond: RTL
======================

// Module: lemming_bump_cond
// PURPOSE
//  Upstream conditioner for the lemming walker FSM. Synchronises and debounces the raw,
//  asynchronous left/right wall-contact sensors, then emits single-cycle bump_left /
//  bump_right pulses. Each physical contact therefore toggles walker direction exactly once.
//  Outputs connect directly to the walker's bump_left / bump_right inputs on the same clk.
// PARAMETERS
//  SYNC_STAGES  2   flops in each raw-input synchroniser chain (>=2)
//  DB_CYCLES    4   consecutive differing synced samples required to change a debounced level (>=1)
//  HOLDOFF      3   cycles after any emitted pulse during which new pulses are dropped (0 = off)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  areset       in   1  asynchronous active-high reset
//  raw_left     in   1  raw left-wall sensor, asynchronous to clk, may bounce
//  raw_right    in   1  raw right-wall sensor, asynchronous to clk, may bounce
//  bump_left    out  1  one-cycle pulse on a debounced rising edge of the left sensor
//  bump_right   out  1  one-cycle pulse on a debounced rising edge of the right sensor
//  wall_left    out  1  debounced left sensor level
//  wall_right   out  1  debounced right sensor level
// BEHAVIOUR
//  Reset (areset=1, asynchronous): synchroniser flops, wall_*, debounce counters, holdoff
//   counter, bump_* all = 0. Outputs stay 0 while areset is high.
//  Synchroniser: raw_x -> SYNC_STAGES-flop chain -> s_x. No logic before the last stage.
//  Debounce (per side, independent), each clk, counter cnt_x width clog2(DB_CYCLES)+1:
//   - s_x == wall_x             : cnt_x <= 0
//   - s_x != wall_x, cnt_x==DB_CYCLES-1 : wall_x <= s_x, cnt_x <= 0
//   - otherwise                 : cnt_x <= cnt_x+1 (saturates; never wraps)
//   - A mismatch run shorter than DB_CYCLES samples leaves wall_x unchanged.
//  Edge detection: rise_x = (wall_x will go 0->1 on this edge). Falling edges produce no pulse.
//  Pulse, registered, updates on the same edge as wall_x:
//   - bump_x <= rise_x & (hold_cnt==0); otherwise bump_x <= 0.
//   - A pulse is exactly 1 cycle wide, never 2 back-to-back.
//  Holdoff: if either bump is emitted, hold_cnt <= HOLDOFF; else if hold_cnt!=0, hold_cnt-1.
//   - A rise during holdoff is dropped, not queued. wall_x still updates.
//   - Width is clog2(HOLDOFF+1). HOLDOFF=0 means hold_cnt stays 0.
//  Simultaneous: left and right rising on the same edge with hold_cnt==0 -> both pulse
//   that cycle; the walker uses the one matching its direction.
//  Latency: raw_x high and stable from before edge k -> wall_x and bump_x assert after
//   edge k+SYNC_STAGES+DB_CYCLES-1 (defaults: 5 edges after first capture).
//  raw_x already high at reset release -> treated as a rising edge: one pulse at normal latency.
//  Reset mid-operation: all counters cleared, any pending debounce is discarded, no pulse
//   is generated by the reset itself.
// TESTING
//  1 Reset: areset=1 with raw_*=1 -> all outputs 0. Release -> single bump_left and
//    bump_right pulses 5 edges later. wall_*=1 thereafter.
//  2 Clean contact: raw_left 0->1 held 20 cycles -> bump_left high for exactly 1 cycle
//    at latency 5. wall_left=1. bump_right stays 0.
//  3 Bounce: raw_left toggles 1,0,1,0 with 2-cycle periods, then held 1 -> no pulse during
//    the bounce, one pulse DB_CYCLES samples after settling.
//  4 Glitch: raw_right high for 3 cycles (<DB_CYCLES) -> wall_right and bump_right stay 0.
//  5 Holdoff: clean left edge, then right edge 2 cycles after bump_left -> bump_right
//    suppressed, wall_right=1. Right released then re-asserted after holdoff -> bump_right pulses.
//  6 Simultaneous and reset: raw_left and raw_right rise together -> both bumps in the same
//    cycle. areset pulsed when cnt_left=2 -> no pulse, cnt cleared, debounce restarts.

Source files
------------

// File: rtl/lemming_bump_cond_if.sv
// Sensor and bump/wall signal bundle between the lemming walker and its input conditioner.
// The conditioner takes the slave view; whatever drives the raw sensors takes the master view.
interface lemming_bump_cond_if;
  logic raw_left;
  logic raw_right;
  logic bump_left;
  logic bump_right;
  logic wall_left;
  logic wall_right;

  modport master (
    output raw_left, raw_right,
    input  bump_left, bump_right, wall_left, wall_right
  );

  modport slave (
    input  raw_left, raw_right,
    output bump_left, bump_right, wall_left, wall_right
  );
endinterface

// File: rtl/lemming_bump_cond.sv
// Wall-contact conditioner: synchronise, debounce and edge-detect both sensors,
// then emit one-cycle bump pulses with a shared holdoff window after each pulse.
module lemming_bump_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int HOLDOFF     = 3
) (
  input  logic                clk,
  input  logic                areset,
  lemming_bump_cond_if.slave  bus
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  // Keep at least one bit so HOLDOFF=0 still elaborates; the load value is then 0.
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  // Index 0 is the left side, index 1 the right side.
  logic [1:0]             w_raw;
  logic [1:0]             w_sync;
  logic [1:0]             w_rise;
  logic [1:0]             w_bump_nxt;
  logic                   w_hold_clear;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [CW-1:0]          r_cnt  [2];
  logic [1:0]             r_wall;
  logic [1:0]             r_bump;
  logic [HW-1:0]          r_hold;

  assign w_raw = {bus.raw_right, bus.raw_left};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
      end
    end
  end

  assign w_sync[0] = r_sync[0][SYNC_STAGES-1];
  assign w_sync[1] = r_sync[1][SYNC_STAGES-1];

  // A level change commits on the DB_CYCLES-th consecutive differing sample.
  assign w_rise[0] = w_sync[0] & ~r_wall[0] & (r_cnt[0] == CNT_LAST);
  assign w_rise[1] = w_sync[1] & ~r_wall[1] & (r_cnt[1] == CNT_LAST);

  assign w_hold_clear = (r_hold == '0);
  assign w_bump_nxt   = w_rise & {2{w_hold_clear}};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
      r_wall <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_wall[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_wall[i] <= w_sync[i];
          r_cnt[i]  <= '0;
        end else if (r_cnt[i] != '1) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rises landing inside the holdoff window are dropped outright, never queued.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_bump <= '0;
      r_hold <= '0;
    end else begin
      r_bump <= w_bump_nxt;
      if (|w_bump_nxt) begin
        r_hold <= HOLD_LOAD;
      end else if (!w_hold_clear) begin
        r_hold <= r_hold - HW'(1);
      end
    end
  end

  assign bus.bump_left  = r_bump[0];
  assign bus.bump_right = r_bump[1];
  assign bus.wall_left  = r_wall[0];
  assign bus.wall_right = r_wall[1];

endmodule
